// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   - operation mode encodings (3-bit)
//   - controller state encoding (IDLE / RUN)
//   - helper that classifies a mode as a stepping (shift/rotate) operation
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True for modes that move bits; only these can run as a multi-cycle op.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step_unit.sv
// Combinational single-step datapath of the universal shift register.
// Ports:
//   q         current register contents
//   mode      operation to apply (see univ_shift_reg_pkg)
//   s_in      serial fill bit for SHL/SHR
//   d         parallel load data
//   next_q    register contents after one step
//   out_bit   bit shifted/rotated out by this step
//   upd_carry high when out_bit should be captured into carry
module shift_step_unit
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit,
  output logic             upd_carry
);

  logic signed [WIDTH-1:0] q_s;

  assign q_s = q;

  always_comb begin
    next_q    = q;
    out_bit   = 1'b0;
    upd_carry = 1'b0;
    case (mode)
      MODE_LOAD: next_q = d;
      MODE_SHL: begin
        next_q    = {q[WIDTH-2:0], s_in};
        out_bit   = q[WIDTH-1];
        upd_carry = 1'b1;
      end
      MODE_SHR: begin
        next_q    = {s_in, q[WIDTH-1:1]};
        out_bit   = q[0];
        upd_carry = 1'b1;
      end
      MODE_ROL: begin
        next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit   = q[WIDTH-1];
        upd_carry = 1'b1;
      end
      MODE_ROR: begin
        next_q    = {q[0], q[WIDTH-1:1]};
        out_bit   = q[0];
        upd_carry = 1'b1;
      end
      MODE_ASR: begin
        next_q    = q_s >>> 1;
        out_bit   = q[0];
        upd_carry = 1'b1;
      end
      default: ;  // HOLD and reserved mode keep q
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, logical/arithmetic shifts and rotates,
// either as single enabled steps or as a multi-cycle "shift by N" command with
// a start/busy/done handshake.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   n_clr       synchronous active-low clear (aborts a running command)
//   en          step enable (single op in IDLE, advance/stall in RUN)
//   mode        operation select
//   d, s_in     parallel load data, serial fill bit
//   start       begin multi-cycle op (IDLE only), amount = step count
//   Q, Q_bar    register contents and its inverse
//   carry       last bit shifted/rotated out
//   busy, done  command in progress, one-cycle completion pulse
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             n_clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             s_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [2:0]       op_mode;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] next_q;
  logic             out_bit;
  logic             upd_carry;

  // In RUN the latched command drives the datapath; live mode is ignored.
  assign step_mode = (state == ST_RUN) ? op_mode : mode;

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .q        (q_r),
    .mode     (step_mode),
    .s_in     (s_in),
    .d        (d),
    .next_q   (next_q),
    .out_bit  (out_bit),
    .upd_carry(upd_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r     <= '0;
      carry   <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
      op_mode <= MODE_HOLD;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!n_clr) begin
        q_r   <= '0;
        carry <= 1'b0;
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        if (en) begin
          q_r <= next_q;
          if (upd_carry) carry <= out_bit;
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
      end else if (start) begin
        op_mode <= mode;
        cnt     <= amount;
        // Commands with nothing to iterate finish immediately in IDLE.
        if ((amount == '0) || !is_shift_mode(mode)) begin
          if (mode == MODE_LOAD) q_r <= d;
          done <= 1'b1;
        end else begin
          state <= ST_RUN;
        end
      end else if (en) begin
        q_r <= next_q;
        if (upd_carry) carry <= out_bit;
      end
    end
  end

  assign Q     = q_r;
  assign Q_bar = ~q_r;
  assign busy  = (state == ST_RUN);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             n_clr;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             s_in;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             carry;
  logic             busy;
  logic             done;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [7:0] mq;
  logic       mc;

  univ_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset), .n_clr(n_clr), .en(en), .mode(mode), .d(d),
    .s_in(s_in), .start(start), .amount(amount), .Q(Q), .Q_bar(Q_bar),
    .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model expressed with plain integer arithmetic.
  function automatic int m_next(int m, int q, int dd, int s);
    case (m)
      1: return dd;
      2: return (q * 2 + s) % 256;
      3: return q / 2 + s * 128;
      4: return (q * 2) % 256 + q / 128;
      5: return q / 2 + (q % 2) * 128;
      6: return q / 2 + ((q >= 128) ? 128 : 0);
      default: return q;
    endcase
  endfunction

  function automatic int m_out(int m, int q);
    if (m == 2 || m == 4) return q / 128;
    return q % 2;
  endfunction

  function automatic bit m_moves(int m);
    return (m >= 2) && (m <= 6);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input int m, input int dd, input int s);
    if (m_moves(m)) mc = 1'(m_out(m, int'(mq)));
    mq = 8'(m_next(m, int'(mq), dd, s));
  endtask

  // Single enabled op in IDLE; drives and tracks the model only.
  task automatic op1(input logic [2:0] m, input logic [7:0] dd, input logic s);
    mode = m; d = dd; s_in = s; en = 1'b1; start = 1'b0;
    tick;
    model_step(int'(m), int'(dd), int'(s));
    en = 1'b0;
  endtask

  task automatic test_reset;
    op1(3'd1, 8'h5A, 1'b0);
    checks++; if (Q !== 8'h5A) $display("FAIL load5A: Q=%h exp=5a", Q); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (Q !== 8'h00 || Q_bar !== 8'hFF) $display("FAIL async_reset: Q=%h Q_bar=%h exp=00/ff", Q, Q_bar); else passes++;
    checks++; if (carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_ctrl: carry=%b busy=%b done=%b exp=0/0/0", carry, busy, done); else passes++;
    tick;
    reset = 1'b0;
    mq = 8'h00; mc = 1'b0;
    op1(3'd1, 8'hFF, 1'b0);
    op1(3'd2, 8'h00, 1'b0);  // FF -> FE, carry=1
    checks++; if (Q !== mq || carry !== mc) $display("FAIL pre_clr: Q=%h c=%b exp=%h/%b", Q, carry, mq, mc); else passes++;
    n_clr = 1'b0; en = 1'b1; mode = 3'd1; d = 8'h33;
    tick;
    n_clr = 1'b1; en = 1'b0;
    mq = 8'h00; mc = 1'b0;
    checks++; if (Q !== 8'h00 || carry !== 1'b0) $display("FAIL n_clr: Q=%h c=%b exp=00/0", Q, carry); else passes++;
  endtask

  task automatic test_single_step;
    op1(3'd1, 8'hA5, 1'b0);
    op1(3'd2, 8'h00, 1'b1);
    checks++; if (Q !== 8'h4B || carry !== 1'b1) $display("FAIL shl_step: Q=%h c=%b exp=4b/1", Q, carry); else passes++;
    en = 1'b0; mode = 3'd2; s_in = 1'b1;
    tick;
    checks++; if (Q !== 8'h4B) $display("FAIL en0_hold: Q=%h exp=4b", Q); else passes++;
  endtask

  task automatic test_random_single;
    logic [2:0] m;
    logic [7:0] dd;
    logic       s, e;
    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(0, 7)); dd = 8'($urandom); s = 1'($urandom); e = 1'($urandom);
      mode = m; d = dd; s_in = s; en = e; start = 1'b0;
      tick;
      if (e) model_step(int'(m), int'(dd), int'(s));
      checks++;
      if (Q !== mq || Q_bar !== ~mq || carry !== mc)
        $display("FAIL rand_single[%0d] mode=%0d: Q=%h Qb=%h c=%b exp=%h/%h/%b", i, m, Q, Q_bar, carry, mq, ~mq, mc);
      else passes++;
    end
    en = 1'b0;
  endtask

  task automatic test_multi_rotate;
    op1(3'd1, 8'h81, 1'b0);
    mode = 3'd5; amount = 3'd3; start = 1'b1; en = 1'b1;
    tick;
    start = 1'b0; mode = 3'd1; d = 8'hEE; amount = 3'd7;
    checks++; if (busy !== 1'b1 || Q !== 8'h81) $display("FAIL ror_start: busy=%b Q=%h exp=1/81", busy, Q); else passes++;
    tick;
    checks++; if (Q !== 8'hC0 || busy !== 1'b1) $display("FAIL ror_s1: Q=%h busy=%b exp=c0/1", Q, busy); else passes++;
    tick;
    checks++; if (Q !== 8'h60 || busy !== 1'b1) $display("FAIL ror_s2: Q=%h busy=%b exp=60/1", Q, busy); else passes++;
    tick;
    checks++; if (Q !== 8'h30 || busy !== 1'b0 || done !== 1'b1 || carry !== 1'b0)
      $display("FAIL ror_s3: Q=%h busy=%b done=%b c=%b exp=30/0/1/0", Q, busy, done, carry); else passes++;
    en = 1'b0;
    tick;
    checks++; if (done !== 1'b0 || Q !== 8'h30) $display("FAIL ror_done_clr: done=%b Q=%h exp=0/30", done, Q); else passes++;
    mq = 8'h30; mc = 1'b0;
  endtask

  task automatic test_stall;
    int busy_cycles = 0;
    int done_pulses = 0;
    op1(3'd1, 8'h90, 1'b0);
    mode = 3'd6; amount = 3'd2; start = 1'b1; en = 1'b1;
    tick; start = 1'b0;
    busy_cycles += busy; done_pulses += done;
    tick;
    busy_cycles += busy; done_pulses += done;
    checks++; if (Q !== 8'hC8) $display("FAIL asr_s1: Q=%h exp=c8", Q); else passes++;
    en = 1'b0;
    tick;
    busy_cycles += busy; done_pulses += done;
    checks++; if (Q !== 8'hC8 || busy !== 1'b1) $display("FAIL asr_stall: Q=%h busy=%b exp=c8/1", Q, busy); else passes++;
    en = 1'b1;
    tick;
    busy_cycles += busy; done_pulses += done;
    en = 1'b0;
    tick;
    busy_cycles += busy; done_pulses += done;
    checks++; if (Q !== 8'hE4 || busy_cycles != 3 || done_pulses != 1)
      $display("FAIL asr_run: Q=%h busy_cycles=%0d done_pulses=%0d exp=e4/3/1", Q, busy_cycles, done_pulses); else passes++;
    mq = 8'hE4; mc = 1'b0;
  endtask

  task automatic test_abort;
    int done_seen = 0;
    op1(3'd1, 8'h01, 1'b0);
    mode = 3'd2; amount = 3'd5; s_in = 1'b0; start = 1'b1; en = 1'b1;
    tick; start = 1'b0; done_seen += done;
    tick; done_seen += done;
    tick; done_seen += done;
    checks++; if (Q !== 8'h04 || busy !== 1'b1) $display("FAIL abort_pre: Q=%h busy=%b exp=04/1", Q, busy); else passes++;
    n_clr = 1'b0;
    tick; done_seen += done;
    n_clr = 1'b1; en = 1'b0;
    checks++; if (Q !== 8'h00 || busy !== 1'b0 || carry !== 1'b0) $display("FAIL abort: Q=%h busy=%b c=%b exp=00/0/0", Q, busy, carry); else passes++;
    mode = 3'd2; amount = 3'd2; s_in = 1'b1; start = 1'b1; en = 1'b1;
    tick; start = 1'b0; done_seen += done;
    checks++; if (busy !== 1'b1 || done_seen != 0) $display("FAIL abort_restart: busy=%b done_seen=%0d exp=1/0", busy, done_seen); else passes++;
    tick; tick;
    checks++; if (Q !== 8'h03 || done !== 1'b1) $display("FAIL abort_rerun: Q=%h done=%b exp=03/1", Q, done); else passes++;
    en = 1'b0;
    tick;
    mq = 8'h03; mc = 1'b0;
  endtask

  task automatic test_zero_amount;
    int busy_seen = 0;
    op1(3'd1, 8'h3C, 1'b0);
    mode = 3'd2; amount = 3'd0; s_in = 1'b1; start = 1'b1; en = 1'b1;
    tick; start = 1'b0; en = 1'b0;
    busy_seen += busy;
    checks++; if (done !== 1'b1 || Q !== 8'h3C) $display("FAIL amt0: done=%b Q=%h exp=1/3c", done, Q); else passes++;
    tick; busy_seen += busy;
    checks++; if (done !== 1'b0 || busy_seen != 0 || Q !== 8'h3C) $display("FAIL amt0_after: done=%b busy_seen=%0d Q=%h exp=0/0/3c", done, busy_seen, Q); else passes++;
    mode = 3'd1; amount = 3'd4; d = 8'h77; start = 1'b1;
    tick; start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || Q !== 8'h77) $display("FAIL load_cmd: done=%b busy=%b Q=%h exp=1/0/77", done, busy, Q); else passes++;
    tick;
    mq = 8'h77;
  endtask

  task automatic test_start_during_run;
    int steps = 0;
    int guard = 0;
    op1(3'd1, 8'h13, 1'b0);
    mode = 3'd4; amount = 3'd4; start = 1'b1; en = 1'b1;
    tick;
    while (done !== 1'b1 && guard < 20) begin
      start = (guard == 1); mode = 3'd3; amount = 3'd7;
      tick;
      steps++; guard++;
    end
    start = 1'b0; en = 1'b0;
    checks++; if (steps != 4 || Q !== 8'h31) $display("FAIL start_in_run: steps=%0d Q=%h exp=4/31", steps, Q); else passes++;
    tick;
    mq = 8'h31; mc = 1'b1;
  endtask

  task automatic test_back_to_back;
    op1(3'd1, 8'h02, 1'b0);
    mode = 3'd5; amount = 3'd1; start = 1'b1; en = 1'b1;
    tick; start = 1'b0;
    tick;
    checks++; if (Q !== 8'h01 || done !== 1'b1) $display("FAIL b2b_first: Q=%h done=%b exp=01/1", Q, done); else passes++;
    mode = 3'd2; amount = 3'd2; s_in = 1'b0; start = 1'b1;
    tick; start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: busy=%b done=%b exp=1/0", busy, done); else passes++;
    tick; tick;
    checks++; if (Q !== 8'h04 || done !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_second: Q=%h done=%b busy=%b exp=04/1/0", Q, done, busy); else passes++;
    en = 1'b0;
    tick;
    mq = 8'h04; mc = 1'b0;
  endtask

  task automatic test_random_multi;
    logic [2:0] m;
    logic [7:0] dd;
    int         n, guard;
    logic       e;
    for (int i = 0; i < 12; i++) begin
      m = 3'($urandom_range(0, 7)); n = $urandom_range(0, 7); dd = 8'($urandom);
      mode = m; amount = 3'(n); d = dd; s_in = 1'($urandom); start = 1'b1; en = 1'($urandom);
      tick;
      start = 1'b0;
      if (n == 0 || !m_moves(int'(m))) begin
        if (m == 3'd1) mq = dd;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || Q !== mq)
          $display("FAIL rand_multi_imm[%0d]: done=%b busy=%b Q=%h exp=1/0/%h", i, done, busy, Q, mq);
        else passes++;
      end else begin
        guard = 0;
        while (n > 0 && guard < 200) begin
          e = 1'($urandom);
          en = e; s_in = 1'($urandom); mode = 3'($urandom); d = 8'($urandom);
          amount = 3'($urandom); start = 1'($urandom);
          tick;
          if (e) begin
            model_step(int'(m), 0, int'(s_in));
            n--;
          end
          guard++;
        end
        start = 1'b0;
        checks++;
        if (n != 0 || Q !== mq || carry !== mc || done !== 1'b1 || busy !== 1'b0)
          $display("FAIL rand_multi[%0d] mode=%0d: Q=%h c=%b done=%b busy=%b exp=%h/%b/1/0 left=%0d", i, m, Q, carry, done, busy, mq, mc, n);
        else passes++;
      end
      en = 1'b0;
      tick;
    end
  endtask

  initial begin
    reset = 1'b1; n_clr = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00;
    s_in = 1'b0; start = 1'b0; amount = 3'd0;
    mq = 8'h00; mc = 1'b0;
    tick; tick;
    reset = 1'b0;
    test_reset;
    test_single_step;
    test_random_single;
    test_multi_rotate;
    test_stall;
    test_abort;
    test_zero_amount;
    test_start_during_run;
    test_back_to_back;
    test_random_multi;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register that generalises the single-bit enabled D flip-flop to a WIDTH-bit register. It supports hold, parallel load, logical and arithmetic shifts, and rotates. Single-step operations are gated by en. A multi-cycle "shift by N" command uses a start/busy/done handshake. It is the building block for serial links, shift-add arithmetic and pattern generators.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 3, width of shift-amount input; N ranges 0..2^AMT_W-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
n_clr  input  1  synchronous clear, active-low
en  input  1  step enable: single op in IDLE, advance/stall in RUN
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
s_in  input  1  serial fill bit for SHL/SHR
start  input  1  begin multi-cycle op (sampled in IDLE only)
amount  input  AMT_W  step count for multi-cycle op
Q  output  WIDTH  register contents
Q_bar  output  WIDTH  bitwise inverse of Q
carry  output  1  last bit shifted or rotated out (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on multi-cycle op completion

Behaviour:
- Reset is asynchronous, active-high, one clock. On reset: Q=0, Q_bar=all ones, carry=0, busy=0, done=0, state=IDLE, step counter=0.
- Mode encoding:
  - 0 HOLD
  - 1 LOAD: Q<=d
  - 2 SHL: {Q[W-2:0],s_in}
  - 3 SHR: {s_in,Q[W-1:1]}
  - 4 ROL
  - 5 ROR
  - 6 ASR: fill with Q[W-1]
  - 7 reserved, behaves as HOLD
- carry: SHL/ROL capture Q[W-1]; SHR/ROR/ASR capture Q[0]. HOLD, LOAD and mode 7 leave carry unchanged.
- Per-edge priority: reset > n_clr > RUN step > IDLE start > IDLE single op.
- n_clr=0 (any state):
  - Q<=0, carry<=0, state<=IDLE, busy<=0.
  - done<=0; an aborted op never pulses done.
- IDLE, start=0, en=1: apply mode once. en=0: hold.
- IDLE, start=1: this takes precedence over the en single op in the same cycle.
  - Latch mode into op_mode and amount into the counter.
  - amount=0, or mode HOLD/LOAD/7: perform LOAD if mode=1, else no change. Stay IDLE. done=1 for exactly one cycle following that edge.
  - Otherwise: state<=RUN, busy=1 from the next cycle.
- RUN:
  - Each edge with en=1 applies op_mode once and decrements the counter. en=0 stalls with Q, counter and carry held.
  - The edge that applies the last step sets state<=IDLE, busy<=0, done<=1.
  - Latency from the start edge: N edges with en=1, plus any stall cycles.
  - start, mode, amount, d and s_in are ignored in RUN, except that s_in is sampled on every step of SHL/SHR.
- done is high for exactly one cycle and is cleared on the next edge. A start is accepted on the same cycle done is high, since state is IDLE.
- Q_bar is always ~Q (combinational from Q).

Decomposition:
- Package univ_shift_reg_pkg holds:
  - mode localparams MODE_HOLD..MODE_ASR
  - state encoding ST_IDLE/ST_RUN
- Sub-module shift_step_unit (combinational, parametrised WIDTH):
  - inputs: q, mode, s_in, d
  - outputs: next_q, out_bit, upd_carry
- Instantiate it once. The top holds the state register, counter and handshake.

Test Plan:
- Reset and clear: assert reset mid-cycle with Q=8'h5A -> Q=8'h00 and Q_bar=8'hFF immediately, without waiting for a clock edge. Then LOAD 8'hFF followed by n_clr=0 on the next edge -> Q=8'h00, carry=0.
- Single-step shift: LOAD 8'hA5, then SHL with s_in=1, en=1 for one edge -> Q=8'h4B, carry=1. Next edge with en=0 -> Q holds 8'h4B.
- Multi-cycle rotate: Q=8'h81, start ROR with amount=3 -> busy high for 3 cycles, Q goes C0, 60, 30. After the 3rd step edge: busy=0, done=1 for one cycle, carry=0.
- Stall mid-run: Q=8'h90, start ASR with amount=2, en=0 for the second RUN cycle -> busy high for 3 cycles, Q ends at 8'hE4, done pulses once.
- Abort: start SHL with amount=5 on Q=8'h01, then n_clr=0 after 2 steps -> Q=8'h00, busy=0, and done never asserts. A new start on the following cycle is accepted.
- Boundaries:
  - start with amount=0 -> done=1 next cycle, Q unchanged, busy never asserts.
  - start pulsed during RUN -> ignored; the step count is unaffected.
  - start on the same cycle done is high -> accepted.
